// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper phase decoder: half-step coil pattern
// table, idle pattern, tracking state type, fault codes and a pattern decoder.
package stepper_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        TRACKING = 2'd1,
        FAULT    = 2'd2
    } state_t;

    localparam logic [3:0] IDLE = 4'b0000;

    // Half-step sequence, indexed by phase 0..7.
    localparam logic [3:0] PHASE_TABLE [8] = '{
        4'b1000, 4'b1100, 4'b0100, 4'b0110,
        4'b0010, 4'b0011, 4'b0001, 4'b1001
    };

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_ILLEGAL = 2'b01;
    localparam logic [1:0] FC_SKIP    = 2'b10;

    typedef struct packed {
        logic       legal;
        logic       idle;
        logic [2:0] idx;
    } decode_t;

    // Classifies a coil pattern as legal phase (with its index), idle, or neither.
    function automatic decode_t decode_pattern(input logic [3:0] pat);
        decode_t d;
        d.legal = 1'b0;
        d.idle  = (pat == IDLE);
        d.idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pat == PHASE_TABLE[i]) begin
                d.legal = 1'b1;
                d.idx   = 3'(i);
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/coil_sync_filter.sv
// Two-flop synchroniser for the asynchronous coil pattern followed by a
// stability filter: a pattern is accepted once, after it has been seen on
// STABLE_CYCLES consecutive edges, and is not re-accepted while held.
module coil_sync_filter #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] coil_in,
    output logic [3:0] pattern,
    output logic       accept
);

    localparam int            CW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          accept_next;

    // Stability count: restart on a change, count up to the threshold, then hold.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        cnt_next    = cnt;
        accept_next = 1'b0;
        if (sync2 != pattern) begin
            cnt_next = CW'(1);
        end else if (cnt < CNT_MAX) begin
            cnt_next = cnt + CW'(1);
        end
        // Strobe only on the transition into "stable", never while held there.
        accept_next = (cnt_next == CNT_MAX) && ((cnt != CNT_MAX) || (sync2 != pattern));
    end

    // Synchroniser, candidate pattern, counter and registered accept strobe.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so each flop samples values from before the edge.
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            pattern <= '0;
            cnt     <= '0;
            accept  <= 1'b0;
        end else begin
            sync1   <= coil_in;
            sync2   <= sync1;
            pattern <= sync2;
            cnt     <= cnt_next;
            accept  <= accept_next;
        end
    end

endmodule

// File: rtl/stepper_phase_decoder.sv
// Stepper phase decoder: recovers phase, step direction and signed position
// from an observed half-step coil pattern, and flags illegal or skipped phases.
// Optional step-interval measurement is built when STEPPER_DEC_RATE_EN is defined.
module stepper_phase_decoder
    import stepper_pkg::*;
#(
    parameter int POS_W         = 16,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              coil_in,
    input  logic                    clear_pos,
    input  logic                    clear_fault,
    output logic [2:0]              phase,
    output logic                    phase_valid,
    output logic                    step_pulse,
    output logic                    step_dir,
    output logic signed [POS_W-1:0] position,
    output logic                    locked,
    output logic                    fault,
    output logic [1:0]              fault_code,
    output logic [15:0]             step_period
);

    logic [3:0] filt;
    logic       accept;
    decode_t    dec;
    logic [2:0] delta;
    logic       illegal_evt;
    logic       skip_evt;
    logic       step_up;
    logic       step_dn;
    state_t     state;
    state_t     state_next;

    coil_sync_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .clk    (clk),
        .rst    (rst),
        .coil_in(coil_in),
        .pattern(filt),
        .accept (accept)
    );

    assign dec   = decode_pattern(filt);
    assign delta = dec.idx - phase;   // modulo-8 phase distance

    assign illegal_evt = accept && !dec.legal && !dec.idle;
    assign skip_evt    = accept && dec.legal && (delta >= 3'd2) && (delta <= 3'd6);
    assign step_up     = accept && (state == TRACKING) && dec.legal && (delta == 3'd1);
    assign step_dn     = accept && (state == TRACKING) && dec.legal && (delta == 3'd7);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= UNLOCKED;
        else     state <= state_next;
    end

    // Next-state logic; a fresh fault outranks a simultaneous clear_fault.
    always_comb begin
        state_next = state;
        case (state)
            UNLOCKED: begin
                if (illegal_evt)                state_next = FAULT;
                else if (accept && dec.legal)   state_next = TRACKING;
            end
            TRACKING: begin
                if (illegal_evt || skip_evt)    state_next = FAULT;
            end
            FAULT: begin
                if (clear_fault && !illegal_evt && !skip_evt) state_next = UNLOCKED;
            end
            default: state_next = UNLOCKED;
        endcase
    end

    // State-decoded status outputs.
    always_comb begin
        locked = (state == TRACKING);
        fault  = (state == FAULT);
    end

    // Phase, step strobe, direction, position and fault cause.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase       <= '0;
            phase_valid <= 1'b0;
            step_pulse  <= 1'b0;
            step_dir    <= 1'b0;
            position    <= '0;
            fault_code  <= FC_NONE;
        end else begin
            step_pulse <= step_up || step_dn;
            if (step_up)      step_dir <= 1'b1;
            else if (step_dn) step_dir <= 1'b0;

            if (clear_pos)    position <= '0;
            else if (step_up) position <= position + POS_W'(1);
            else if (step_dn) position <= position - POS_W'(1);

            // In FAULT the observed patterns are ignored entirely.
            if (accept && (state != FAULT)) begin
                if (dec.legal) begin
                    phase       <= dec.idx;
                    phase_valid <= 1'b1;
                end else begin
                    phase_valid <= 1'b0;
                end
            end

            // Latch the first cause on entry; clear it only when leaving FAULT.
            if ((state != FAULT) && (state_next == FAULT))
                fault_code <= illegal_evt ? FC_ILLEGAL : FC_SKIP;
            else if ((state == FAULT) && (state_next == UNLOCKED))
                fault_code <= FC_NONE;
        end
    end

`ifdef STEPPER_DEC_RATE_EN
    logic [15:0] rate_cnt;

    // Saturating interval counter between accepted steps.
    always_ff @(posedge clk) begin
        if (rst) begin
            rate_cnt    <= '0;
            step_period <= '0;
        end else if ((state != UNLOCKED) && (state_next == UNLOCKED)) begin
            rate_cnt <= '0;
        end else if (step_up || step_dn) begin
            step_period <= rate_cnt;
            rate_cnt    <= 16'd1;
        end else if (rate_cnt != 16'hFFFF) begin
            rate_cnt <= rate_cnt + 16'd1;
        end
    end
`else
    assign step_period = '0;
`endif

endmodule

// File: doc/stepper_phase_decoder.md
Name: stepper_phase_decoder

Overview:
- Observes a 4-bit half-step coil pattern, from the stepper drive outputs or a loop-back tap, and recovers motion from it.
- Synchronises and filters the pattern, decodes it to a phase index 0..7, detects single steps and their direction, and accumulates a signed position.
- Flags illegal patterns and skipped phases.
- Used as the position-feedback and self-check monitor alongside the stepper drive.

Parameters:
- POS_W, 16, width of the signed position accumulator.
- STABLE_CYCLES, 4, number of consecutive identical synchronised samples required before a pattern is accepted (minimum 1).

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  synchronous active-high reset.
- coil_in  in  4  observed coil pattern; asynchronous to clk.
- clear_pos  in  1  synchronous clear of position.
- clear_fault  in  1  leave FAULT and return to UNLOCKED.
- phase  out  3  last accepted phase index.
- phase_valid  out  1  high while the accepted pattern is a legal phase.
- step_pulse  out  1  one-cycle strobe per accepted single step.
- step_dir  out  1  direction of last step: 1 = up (phase+1), 0 = down.
- position  out  POS_W  signed step count, two's complement.
- locked  out  1  high in TRACKING.
- fault  out  1  high in FAULT.
- fault_code  out  2  00 none, 01 illegal pattern, 10 skipped phase.
- step_period  out  16  cycles between the last two accepted steps (optional feature only).

Behaviour:
- Reset values: all outputs 0; internal state UNLOCKED; filter counter 0.
- Phase table: 0=1000, 1=1100, 2=0100, 3=0110, 4=0010, 5=0011, 6=0001, 7=1001.
- Idle pattern: 0000 means coils off.
- Illegal patterns: every other code.
- Synchroniser: two flops on coil_in.
- Filter: a pattern is accepted when the synchroniser output has been identical on STABLE_CYCLES consecutive edges. It is accepted once per change; no re-acceptance while it is held.
- Latency: a new coil_in value first captured at edge E0 gives registered outputs at edge E0+STABLE_CYCLES+2.
- Idle accepted: phase_valid=0; last phase retained; state unchanged; no step.
- State UNLOCKED, on a legal phase accepted: load phase; phase_valid=1; go to TRACKING. No step_pulse; position unchanged.
- State TRACKING, on a legal phase accepted, with delta = (new - phase) mod 8:
  - delta 1: step_pulse, step_dir=1, position+1.
  - delta 7: step_pulse, step_dir=0, position-1.
  - delta 2..6: go to FAULT, fault_code=10, no position update.
  - Phase register updated to the new value in all of these cases.
- Illegal pattern accepted in UNLOCKED or TRACKING: go to FAULT, fault_code=01, phase_valid=0.
- State FAULT:
  - Position frozen; further patterns are ignored for stepping.
  - fault_code keeps its first cause.
  - clear_fault: go to UNLOCKED, fault_code=00.
- Position wraps modulo 2^POS_W with no saturation.
- clear_pos asserted in the same cycle as a step: clear wins, position=0.
- clear_fault asserted in the same cycle as a new illegal or skip acceptance: the fault wins and the state stays in FAULT.
- rst at any time: all outputs and internal state return to reset values on the next edge, including a filter count in progress.

Optional Feature:
- Macro: STEPPER_DEC_RATE_EN.
- Enabled: a 16-bit cycle counter runs between accepted steps, saturating at 0xFFFF. On each step_pulse, step_period takes the counter value and the counter restarts at 1. The counter also resets on rst and on entry to UNLOCKED.
- Disabled: step_period is tied to 0 and no counter logic exists.

Decomposition:
- Package stepper_pkg holds:
  - the phase-pattern constant table (8 x 4 bits) and the IDLE constant;
  - the state type {UNLOCKED, TRACKING, FAULT};
  - the fault_code constants.
- Sub-module coil_sync_filter: two-flop synchroniser plus the STABLE_CYCLES stability counter. Outputs are the filtered pattern and a one-cycle accept strobe.

Test Plan (STABLE_CYCLES=4, POS_W=16):
- Reset, then coil_in=1000 held 10 cycles: locked=1, phase=0, position=0, no step_pulse. The outputs change exactly at edge E0+6.
- From phase 0, walk 1100, 0100, 0110 with each pattern held 8 cycles: three step_pulses, step_dir=1, position=3. Then walk back 0100, 1100, 1000, 1001: position=-1 (0xFFFF), step_dir=0.
- Glitch 0110 for 3 cycles, then back to 1000: no acceptance, no step, position unchanged.
- From phase 0, jump to 0010 (phase 4): fault=1, fault_code=10, locked=0, position frozen. Pulse clear_fault: fault=0, state UNLOCKED; the next legal pattern relocks without a step.
- Apply 1111: fault_code=01, phase_valid=0. Apply 0000 while TRACKING: phase_valid=0, phase retained; returning to the same phase gives no step.
- Preload position to 0x7FFF via 32767 up-steps, then one more up-step: position=0x8000. clear_pos coincident with a step gives position=0.
- With STEPPER_DEC_RATE_EN defined: steps spaced 20 cycles apart give step_period=20.
